// File: rtl/sret_sequencer_if.sv
// sret_sequencer_if: decoder/CSR/fetch-side signal bundle of the SRET return sequencer (optional TSR pins under HARVOS_SRET_TSR_EN)
interface sret_sequencer_if #(parameter int XLEN = 32);
    logic            sret_pulse;
    logic [XLEN-1:0] sepc_i;
    logic            sstatus_spp_i;
    logic            sstatus_spie_i;
    logic            flush_req;
    logic            flush_done;
    logic            sstatus_we;
    logic            sie_nxt;
    logic            spie_nxt;
    logic            spp_nxt;
    logic            priv_we;
    logic [1:0]      priv_nxt;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;
    logic            busy;
    logic            dropped;
    logic            flush_err;
`ifdef HARVOS_SRET_TSR_EN
    logic            tsr_i;
    logic            illegal_o;
`endif

    modport slave (
`ifdef HARVOS_SRET_TSR_EN
        input  tsr_i,
        output illegal_o,
`endif
        input  sret_pulse, sepc_i, sstatus_spp_i, sstatus_spie_i, flush_done, redirect_ready,
        output flush_req, sstatus_we, sie_nxt, spie_nxt, spp_nxt, priv_we, priv_nxt,
        output redirect_valid, redirect_pc, busy, dropped, flush_err
    );

    modport master (
`ifdef HARVOS_SRET_TSR_EN
        output tsr_i,
        input  illegal_o,
`endif
        output sret_pulse, sepc_i, sstatus_spp_i, sstatus_spie_i, flush_done, redirect_ready,
        input  flush_req, sstatus_we, sie_nxt, spie_nxt, spp_nxt, priv_we, priv_nxt,
        input  redirect_valid, redirect_pc, busy, dropped, flush_err
    );
endinterface

// File: rtl/sret_sequencer.sv
// sret_sequencer: SRET flush/commit/redirect sequencer; HARVOS_SRET_TSR_EN adds the TSR trap check
module sret_sequencer #(
    parameter int XLEN          = 32,
    parameter int FLUSH_TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst_n,
    sret_sequencer_if.slave sif
);
    localparam int CW = $clog2(FLUSH_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            spp_q, spp_d;
    logic            spie_q, spie_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            drop_q, drop_d;
    logic            ill_q, ill_d;
    logic            trap;
    logic            accept;

`ifdef HARVOS_SRET_TSR_EN
    assign trap          = sif.tsr_i;
    assign sif.illegal_o = ill_q;
`else
    assign trap = 1'b0;
`endif

    assign accept = sif.sret_pulse && (state_q == IDLE) && !trap;

    // Next-state logic: capture on accept, count down the drain window, wait for the redirect handshake
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        spp_d   = spp_q;
        spie_d  = spie_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        drop_d  = sif.sret_pulse && (state_q != IDLE);
        ill_d   = sif.sret_pulse && (state_q == IDLE) && trap;
        case (state_q)
            IDLE: if (accept) begin
                tgt_d   = {sif.sepc_i[XLEN-1:2], 2'b00};
                spp_d   = sif.sstatus_spp_i;
                spie_d  = sif.sstatus_spie_i;
                cnt_d   = CW'(FLUSH_TIMEOUT);
                state_d = DRAIN;
            end
            DRAIN: begin
                if (sif.flush_done) state_d = COMMIT;
                else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    state_d = COMMIT;
                end else cnt_d = cnt_q - CW'(1);
            end
            COMMIT:   state_d = REDIRECT;
            REDIRECT: state_d = sif.redirect_ready ? IDLE : REDIRECT;
            default:  state_d = IDLE;
        endcase
    end

    // State and captured context; async reset aborts any sequence in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            spp_q   <= 1'b0;
            spie_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            spp_q   <= spp_d;
            spie_q  <= spie_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            ill_q   <= ill_d;
        end
    end

    assign sif.flush_req      = state_q == DRAIN;
    assign sif.sstatus_we     = state_q == COMMIT;
    assign sif.sie_nxt        = (state_q == COMMIT) && spie_q;
    assign sif.spie_nxt       = state_q == COMMIT;
    assign sif.spp_nxt        = 1'b0;
    assign sif.priv_we        = state_q == COMMIT;
    assign sif.priv_nxt       = ((state_q == COMMIT) && spp_q) ? 2'b01 : 2'b00;
    assign sif.redirect_valid = state_q == REDIRECT;
    assign sif.redirect_pc    = tgt_q;
    assign sif.busy           = state_q != IDLE;
    assign sif.dropped        = drop_q;
    assign sif.flush_err      = err_q;
endmodule

// File: tb/tb_sret_sequencer.sv
// tb_sret_sequencer: scoreboard bench for sret_sequencer (drain window shortened to 4)
module tb_sret_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sret_sequencer_if #(.XLEN(32)) sif ();

    sret_sequencer #(.XLEN(32), .FLUSH_TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    logic [5:0]  cmt_q[$];
    logic [31:0] rd_q[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] all_outs();
        return {sif.flush_req, sif.sstatus_we, sif.sie_nxt, sif.spie_nxt, sif.spp_nxt, sif.priv_we,
                sif.priv_nxt, sif.redirect_valid, sif.busy, sif.dropped, sif.flush_err, sif.redirect_pc};
    endfunction

    // Monitor: pop expected commit strobes and redirect targets as the DUT presents them
    always @(negedge clk) if (rst_n) begin
        if (sif.sstatus_we) begin
            if (cmt_q.size() == 0) chk("commit_unexpected", 1, 0);
            else chk("commit", {sif.priv_we, sif.sie_nxt, sif.spie_nxt, sif.spp_nxt, sif.priv_nxt}, cmt_q.pop_front());
        end
        if (sif.redirect_valid && sif.redirect_ready) begin
            if (rd_q.size() == 0) chk("redirect_unexpected", 1, 0);
            else chk("redirect_pc", sif.redirect_pc, rd_q.pop_front());
        end
    end

    task automatic sret(input logic [31:0] pc, input logic spp, input logic spie,
                        input int dly, input int rdly, input bit done, input bit drop);
        int n;
        cmt_q.push_back({1'b1, spie, 1'b1, 1'b0, spp ? 2'b01 : 2'b00});
        rd_q.push_back(pc & 32'hFFFF_FFFC);
        sif.sepc_i = pc;
        sif.sstatus_spp_i = spp;
        sif.sstatus_spie_i = spie;
        sif.sret_pulse = 1'b1;
        @(posedge clk); #1;
        sif.sret_pulse = 1'b0;
        sif.sepc_i = ~pc;
        sif.sstatus_spp_i = ~spp;
        sif.sstatus_spie_i = ~spie;
        chk("flush_req_t1", sif.flush_req, 1);
        for (int i = 0; i < dly; i++) begin
            if (drop && i == 0) sif.sret_pulse = 1'b1;
            @(posedge clk); #1;
            sif.sret_pulse = 1'b0;
            if (drop && i == 0) chk("dropped", sif.dropped, 1);
            if (drop && i == 1) chk("dropped_one_cycle", sif.dropped, 0);
        end
        if (done) begin
            sif.flush_done = 1'b1;
            @(posedge clk); #1;
            sif.flush_done = 1'b0;
            chk("commit_timing", sif.sstatus_we, 1);
        end
        n = 0;
        while (!sif.redirect_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("redirect_wait", sif.redirect_valid, 1);
        for (int i = 0; i < rdly; i++) begin
            chk("bp_valid", sif.redirect_valid, 1);
            chk("bp_pc", sif.redirect_pc, pc & 32'hFFFF_FFFC);
            @(posedge clk); #1;
        end
        sif.redirect_ready = 1'b1;
        @(posedge clk); #1;
        sif.redirect_ready = 1'b0;
        chk("busy_after_hs", sif.busy, 0);
        chk("valid_after_hs", sif.redirect_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.sret_pulse = 1'b0;
        sif.sepc_i = '0;
        sif.sstatus_spp_i = 1'b0;
        sif.sstatus_spie_i = 1'b0;
        sif.flush_done = 1'b0;
        sif.redirect_ready = 1'b0;
`ifdef HARVOS_SRET_TSR_EN
        sif.tsr_i = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_outputs", all_outs(), 0);
        sret(32'h8000_1236, 1'b1, 1'b1, 3, 0, 1'b1, 1'b0);
        sret(32'h0000_4003, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0);
        sret(32'h1234_5679, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
        sret(32'hCAFE_F00D, 1'b0, 1'b1, 2, 5, 1'b1, 1'b0);
        sret(32'h0000_0100, 1'b1, 1'b1, 3, 0, 1'b1, 1'b1);
        chk("err_before_timeout", sif.flush_err, 0);
        sret(32'hDEAD_BEEF, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("flush_err_set", sif.flush_err, 1);
        sret(32'h0000_2002, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0);
        chk("flush_err_sticky", sif.flush_err, 1);
        sif.sepc_i = 32'hA5A5_A5A4;
        sif.sret_pulse = 1'b1;
        cmt_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 2'b00});
        sif.sstatus_spp_i = 1'b0;
        sif.sstatus_spie_i = 1'b0;
        @(posedge clk); #1;
        sif.sret_pulse = 1'b0;
        sif.flush_done = 1'b1;
        @(posedge clk); #1;
        sif.flush_done = 1'b0;
        @(posedge clk); #1;
        chk("redirect_before_reset", sif.redirect_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_redirect", all_outs(), 0);
        rd_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("after_reset_idle", all_outs(), 0);
`ifdef HARVOS_SRET_TSR_EN
        sif.tsr_i = 1'b1;
        sif.sret_pulse = 1'b1;
        @(posedge clk); #1;
        sif.sret_pulse = 1'b0;
        chk("tsr_illegal", {sif.illegal_o, sif.flush_req, sif.busy, sif.redirect_valid}, 4'b1000);
        @(posedge clk); #1;
        chk("tsr_illegal_pulse", {sif.illegal_o, sif.flush_req, sif.sstatus_we, sif.redirect_valid}, 4'b0000);
        sif.tsr_i = 1'b0;
`endif
        chk("commit_queue_empty", cmt_q.size(), 0);
        chk("redirect_queue_empty", rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
